// File: rtl/exp6_detector_jogada_pkg.sv
// Shared definitions for the play detector: FSM state codes (also shown on the
// debug display) and the one-hot check used to validate a filtered press.
package exp6_detector_jogada_pkg;

  localparam int unsigned MAX_BOTOES = 32;

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    FILTRA  = 3'd1,
    PULSO   = 3'd2,
    REJEITA = 3'd3,
    SOLTA   = 3'd4
  } estado_t;

  // Callers zero-extend narrower button vectors to MAX_BOTOES
  function automatic logic one_hot(input logic [MAX_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - MAX_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/exp6_sincronizador.sv
// Two-flop synchroniser for asynchronous inputs, cleared to zero by reset.
module exp6_sincronizador #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exp6_detector_jogada.sv
// Play detector: synchronises and debounces the push-buttons, emits one pulse
// plus a one-hot code per valid press and flags simultaneous presses.
module exp6_detector_jogada
  import exp6_detector_jogada_pkg::*;
#(
  parameter int unsigned N_BOTOES        = 4,
  parameter int unsigned DEBOUNCE_CICLOS = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                limpa,
  output logic                jogada,
  output logic [N_BOTOES-1:0] jogada_valor,
  output logic                erro_multipla,
  output logic                botoes_soltos,
  output logic [2:0]          db_estado
);

  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

  estado_t             estado, estado_prox;
  logic [N_BOTOES-1:0] s;
  logic [N_BOTOES-1:0] snap, snap_prox;
  logic [N_BOTOES-1:0] valor_prox;
  logic [CNT_W-1:0]    cnt, cnt_prox;

  exp6_sincronizador #(
    .WIDTH(N_BOTOES)
  ) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (botoes),
    .q    (s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= ESPERA;
      cnt          <= '0;
      snap         <= '0;
      jogada_valor <= '0;
    end else begin
      estado       <= estado_prox;
      cnt          <= cnt_prox;
      snap         <= snap_prox;
      jogada_valor <= valor_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    cnt_prox    = cnt;
    snap_prox   = snap;
    // A capture on the same edge overrides the clear below
    valor_prox  = limpa ? '0 : jogada_valor;

    unique case (estado)
      ESPERA: begin
        if (s != '0) begin
          snap_prox   = s;
          cnt_prox    = '0;
          estado_prox = FILTRA;
        end
      end
      FILTRA: begin
        if (s != snap) begin
          estado_prox = ESPERA;
        end else if (cnt == CNT_FIM) begin
          if (one_hot(MAX_BOTOES'(snap))) begin
            estado_prox = PULSO;
            valor_prox  = snap;
          end else begin
            estado_prox = REJEITA;
          end
        end else begin
          cnt_prox = cnt + CNT_W'(1);
        end
      end
      PULSO, REJEITA: begin
        cnt_prox    = '0;
        estado_prox = SOLTA;
      end
      SOLTA: begin
        if (s != '0) begin
          cnt_prox = '0;
        end else if (cnt == CNT_FIM) begin
          estado_prox = ESPERA;
        end else begin
          cnt_prox = cnt + CNT_W'(1);
        end
      end
      default: estado_prox = ESPERA;
    endcase
  end

  assign jogada        = (estado == PULSO);
  assign erro_multipla = (estado == REJEITA);
  assign botoes_soltos = (estado == ESPERA);
  assign db_estado     = estado;

endmodule

// File: tb/tb_exp6_detector_jogada.sv
// Bench for exp6_detector_jogada: directed scenarios plus random button
// activity, scored against a run-length reference model.
module tb_exp6_detector_jogada;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] botoes;
  logic         limpa;
  logic         jogada;
  logic [N-1:0] jogada_valor;
  logic         erro_multipla;
  logic         botoes_soltos;
  logic [2:0]   db_estado;

  always #5 clock = ~clock;

  exp6_detector_jogada #(
    .N_BOTOES       (N),
    .DEBOUNCE_CICLOS(D),
    .CNT_W          (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .limpa        (limpa),
    .jogada       (jogada),
    .jogada_valor (jogada_valor),
    .erro_multipla(erro_multipla),
    .botoes_soltos(botoes_soltos),
    .db_estado    (db_estado)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual === esperado) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit           err;
    logic [N-1:0] val;
    int           cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;

  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  bit           armed = 1'b1;     // released long enough, ready for a new press
  bit           filtering = 1'b0;
  bit           just_emitted = 1'b0;
  logic [N-1:0] p = '0;
  int           stable = 0;       // consecutive samples equal to p, start included
  int           zero_run = 0;     // consecutive all-released samples while cooling
  logic [N-1:0] m_valor = '0;

  function automatic bit exp_soltos();
    return armed && !filtering && !just_emitted;
  endfunction

  always @(posedge clock) begin
    logic [N-1:0] s;
    bit           aceitou;
    ev_t          e;
    cyc++;
    if (reset) begin
      m_s1 = '0; m_s2 = '0;
      armed = 1'b1; filtering = 1'b0; just_emitted = 1'b0;
      stable = 0; zero_run = 0; m_valor = '0;
      sb.delete();
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = botoes;
      aceitou = 1'b0;
      if (just_emitted) begin
        just_emitted = 1'b0;
        zero_run = 0;
      end else if (!armed) begin
        zero_run = (s == '0) ? zero_run + 1 : 0;
        if (zero_run == D) armed = 1'b1;
      end else if (!filtering) begin
        if (s != '0) begin
          filtering = 1'b1; p = s; stable = 1;
        end
      end else if (s != p) begin
        filtering = 1'b0;
      end else begin
        stable++;
        if (stable == D + 1) begin
          filtering = 1'b0; armed = 1'b0; just_emitted = 1'b1;
          e.err = ($countones(p) != 1);
          e.val = p;
          e.cyc = cyc;
          sb.push_back(e);
          aceitou = !e.err;
        end
      end
      if (aceitou) m_valor = p;
      else if (limpa) m_valor = '0;
    end
  end

  // ---------------- monitor ----------------
  int n_jog = 0;
  int n_err = 0;
  int last_jog_cyc = 0;

  always @(posedge clock) begin
    ev_t e;
    #1;
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("evento_perdido_ciclo", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (jogada || erro_multipla) begin
        if (jogada) begin n_jog++; last_jog_cyc = cyc; end
        if (erro_multipla) n_err++;
        if (sb.size() == 0) begin
          chk("pulso_inesperado", 32'({jogada, erro_multipla}), 0);
        end else begin
          e = sb.pop_front();
          chk("pulso_tipo_erro", 32'(erro_multipla), 32'(e.err));
          chk("pulso_tipo_jogada", 32'(jogada), 32'(!e.err));
          chk("pulso_ciclo", cyc, e.cyc);
          if (!e.err) chk("valor_no_pulso", 32'(jogada_valor), 32'(e.val));
        end
      end
      chk("jogada_valor", 32'(jogada_valor), 32'(m_valor));
      chk("botoes_soltos", 32'(botoes_soltos), 32'(exp_soltos()));
      chk("db_estado_espera", 32'(db_estado == 3'd0), 32'(exp_soltos()));
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; holds the pattern for n rising edges.
  task automatic hold(input logic [N-1:0] b, input int unsigned n);
    botoes = b;
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_jogada"}, 32'(jogada), 0);
    chk({tag, "_valor"}, 32'(jogada_valor), 0);
    chk({tag, "_erro"}, 32'(erro_multipla), 0);
    chk({tag, "_soltos"}, 32'(botoes_soltos), 1);
    chk({tag, "_db"}, 32'(db_estado), 0);
  endtask

  initial begin
    int c0, nj0, ne0;
    reset = 1'b1; botoes = '0; limpa = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;
    hold('0, 3);

    // 1: single press held, latency 2+D from edge 0
    c0 = cyc; nj0 = n_jog;
    hold(4'b0100, 20);
    chk("t1_latencia", last_jog_cyc, c0 + 1 + 2 + D);
    chk("t1_um_pulso", n_jog - nj0, 1);
    chk("t1_valor", 32'(jogada_valor), 32'(4'b0100));
    hold('0, 10);

    // 2: bounce then stable press
    nj0 = n_jog;
    hold(4'b0001, 2); hold('0, 1);
    c0 = cyc;
    hold(4'b0001, 15);
    chk("t2_um_pulso", n_jog - nj0, 1);
    chk("t2_latencia", last_jog_cyc, c0 + 1 + 2 + D);
    chk("t2_valor", 32'(jogada_valor), 32'(4'b0001));
    hold('0, 10);

    // 3: simultaneous press rejected
    nj0 = n_jog; ne0 = n_err;
    hold(4'b0011, 10);
    chk("t3_erro_uma_vez", n_err - ne0, 1);
    chk("t3_sem_jogada", n_jog - nj0, 0);
    chk("t3_valor_mantido", 32'(jogada_valor), 32'(4'b0001));
    hold('0, 2 + D + 1);
    chk("t3_soltos", 32'(botoes_soltos), 1);

    // 4: release glitch keeps the detector in its release filter
    nj0 = n_jog;
    hold(4'b1000, 12);
    hold('0, 2); hold(4'b1000, 1); hold('0, 2);
    chk("t4_nao_solto", 32'(botoes_soltos), 0);
    hold('0, 12);
    chk("t4_um_pulso", n_jog - nj0, 1);
    chk("t4_soltos_final", 32'(botoes_soltos), 1);

    // 5: clear coinciding with capture, then clear while idle
    hold(4'b0001, 2 + D);          // next edge is the capture edge
    limpa = 1'b1; hold(4'b0001, 1); limpa = 1'b0;
    chk("t5_captura_vence", 32'(jogada_valor), 32'(4'b0001));
    hold('0, 12);
    limpa = 1'b1; hold('0, 1); limpa = 1'b0;
    chk("t5_limpa_espera", 32'(jogada_valor), 0);

    // 6: reset mid-filter
    nj0 = n_jog;
    hold(4'b0010, 4);
    reset = 1'b1;
    #1 chk_reset_vals("t6_reset");
    hold(4'b0010, 2);
    reset = 1'b0;
    hold('0, 6);
    chk("t6_sem_pulso", n_jog - nj0, 0);
    c0 = cyc;
    hold(4'b0010, 12);
    chk("t6_pulso_apos", n_jog - nj0, 1);
    chk("t6_latencia", last_jog_cyc, c0 + 1 + 2 + D);
    hold('0, 10);

    // random activity
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [N-1:0] b;
      r = $urandom_range(0, 99);
      if (r < 65) b = N'(1 << $urandom_range(0, N - 1));
      else if (r < 80) b = N'($urandom_range(1, (1 << N) - 1));
      else b = '0;
      limpa = ($urandom_range(0, 9) == 0);
      hold(b, 1);
      limpa = 1'b0;
      hold(b, $urandom_range(0, 11));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        hold(b, $urandom_range(1, 2));
        reset = 1'b0;
      end
    end
    hold('0, 20);
    chk("fila_vazia", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exp6_detector_jogada.md
Name: exp6_detector_jogada

Overview:
- Input stage directly upstream of the game control unit.
- Synchronises and debounces the player's raw push-buttons and rejects simultaneous presses.
- For each valid press, emits exactly one single-cycle `jogada` pulse plus a registered one-hot `jogada_valor`; these feed the control unit's `jogada` input and the datapath's play register.
- Also exports a release flag and a debug state code for the 7-segment debug display.

Parameters:
N_BOTOES, 4, number of buttons; width of `botoes` and `jogada_valor`.
DEBOUNCE_CICLOS, 4, consecutive stable cycles required on press and on release (min 1).
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CICLOS.

Ports:
clock  in  1  system clock, single domain.
reset  in  1  asynchronous, active-high; clears all state.
botoes  in  N_BOTOES  raw asynchronous buttons, 1 = pressed.
limpa  in  1  synchronous clear of `jogada_valor` (driven alongside limpaRC).
jogada  out  1  one-cycle pulse per accepted press.
jogada_valor  out  N_BOTOES  one-hot code of last accepted press; held until next accept or `limpa`.
erro_multipla  out  1  one-cycle pulse when a stable non-one-hot press is rejected.
botoes_soltos  out  1  high in ESPERA only (all buttons released and filtered).
db_estado  out  3  current state code.

Behaviour:
- Reset values: state ESPERA; sync regs 0; counter 0; `jogada`=0; `jogada_valor`=0; `erro_multipla`=0. `botoes_soltos`=1 and `db_estado`=0, since both follow the state.
- Synchroniser: 2-FF on every bit of `botoes`. Call its output `s`. FSM decisions use `s` only.
- Registered `snap` (N_BOTOES) holds the press pattern under test.
- States (db_estado code):
  - ESPERA (0): if `s`≠0, then `snap`←`s`, cnt←0, go to FILTRA. Otherwise stay.
  - FILTRA (1):
    - if `s`≠`snap`, go to ESPERA (bounce or pattern change; no output);
    - else if cnt==DEBOUNCE_CICLOS-1: if `snap` is one-hot, go to PULSO and `jogada_valor`←`snap` on the same edge; otherwise go to REJEITA;
    - else cnt←cnt+1.
  - PULSO (2): `jogada`=1, Moore output for exactly this one cycle. Unconditionally go to SOLTA with cnt←0.
  - REJEITA (3): `erro_multipla`=1 for one cycle. Unconditionally go to SOLTA with cnt←0.
  - SOLTA (4): if `s`≠0, cnt←0 and stay. Else if cnt==DEBOUNCE_CICLOS-1, go to ESPERA. Else cnt←cnt+1.
  - Codes 5–7 are illegal; they go to ESPERA next cycle, with `db_estado` showing the raw code.
- Latency: with a raw press stable from before rising edge 0, FILTRA is entered after edge 2 and PULSO after edge 2+DEBOUNCE_CICLOS.
- Release: after `s` returns to 0, ESPERA is re-entered DEBOUNCE_CICLOS edges later.
- Holding a button never produces a second pulse; only a filtered release followed by a new press does.
- Pattern changes during FILTRA (e.g. a second button added) restart filtering from ESPERA.
- `limpa` clears `jogada_valor` on the next edge in any state. If it coincides with the FILTRA→PULSO capture, the capture wins.
- An asynchronous `reset` mid-filter or mid-pulse aborts immediately. No pulse is emitted after reset deasserts until a fresh full press has been filtered.
- Counter width: cnt never exceeds DEBOUNCE_CICLOS-1; no wrap is possible.

Decomposition:
- Shared package holds the state encodings (ESPERA..SOLTA, 3-bit) and a `one_hot` check function. The same encodings are used by the top-level debug hex mux.
- One natural sub-module: `exp6_sincronizador`, parameterised width, 2-FF, async reset to 0. The FSM, counter and registers stay in the top module.

Test Plan:
1. Reset then `botoes`=0100 held 20 cycles (D=4): `jogada`=1 only in the cycle after edge 6; `jogada_valor`=0100 from edge 6; no further pulse while held.
2. Bounce: 0001 for 2 cycles, 0 for 1, then 0001 held: no pulse from the bounce; exactly one pulse 2+4 edges after the final stable edge; `jogada_valor`=0001.
3. Multiple press 0011 held 10 cycles: `erro_multipla` pulses once, `jogada` stays 0, `jogada_valor` keeps its prior value; after release plus 4 cycles `botoes_soltos`=1.
4. Release glitch: after an accepted 1000, release, re-press for 1 cycle within 4 cycles, then release: state remains SOLTA until 4 clean zero cycles; no second `jogada`.
5. `limpa` asserted in the same cycle as the FILTRA→PULSO edge: `jogada_valor`=new code. `limpa` in ESPERA: `jogada_valor`→0 next edge.
6. `reset` pulsed while in FILTRA with 0010 held: outputs return to reset values immediately. After release, one pulse for 0010 occurs only after a full sync-plus-filter sequence.
